aes_byte_ctrl: RTL and testbench

Byte-serial command controller between the HPS-exported 8-bit Avalon conduit (read, write, writedata, readdata) and the AES core. It decodes a command byte stream, assembles the 128-bit key and data block, launches the core, watches for completion or timeout, and returns the 16 result bytes on subsequent reads. It owns all AES sequencing; software only issues byte writes and reads.

---
 rtl/aes_byte_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_aes_byte_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/aes_byte_ctrl.sv
// rtl/aes_byte_ctrl.sv - byte-serial command controller for the AES core
// Decodes an 8-bit command stream, assembles key/data, launches the core and returns results.
module aes_byte_ctrl #(
  parameter int TIMEOUT = 1024
) (
  input  logic         clk_clk,
  input  logic         reset_reset_n,
  input  logic         soft_reset,
  input  logic         avs_read,
  input  logic         avs_write,
  input  logic [7:0]   avs_writedata,
  output logic [7:0]   avs_readdata,
  output logic [127:0] aes_key,
  output logic [127:0] aes_din,
  output logic         aes_start,
  input  logic         aes_done,
  input  logic [127:0] aes_dout
);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_KEY, S_DATA, S_START, S_BUSY, S_DONE, S_OUT
  } state_t;

  state_t         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic           key_valid_q, key_valid_d;
  logic           err_q, err_d;
  logic [127:0]   key_q, key_d;
  logic [127:0]   din_q, din_d;
  logic [127:0]   result_q, result_d;
  logic [7:0]     rdata_q, rdata_d;
  logic [TW-1:0]  tmo_q, tmo_d;

  logic [7:0]     status;
  logic [7:0]     result_byte;
  logic [6:0]     byte_pos;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      key_valid_q <= 1'b0;
      err_q       <= 1'b0;
      key_q       <= '0;
      din_q       <= '0;
      result_q    <= '0;
      rdata_q     <= '0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      key_valid_q <= key_valid_d;
      err_q       <= err_d;
      key_q       <= key_d;
      din_q       <= din_d;
      result_q    <= result_d;
      rdata_q     <= rdata_d;
      tmo_q       <= tmo_d;
    end
  end

  // Byte cnt sits at bit offset 8*(15-cnt) so byte 0 lands in the top bits.
  assign byte_pos = {~cnt_q, 3'b000};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    key_valid_d = key_valid_q;
    err_d       = err_q;
    key_d       = key_q;
    din_d       = din_q;
    result_d    = result_q;
    rdata_d     = rdata_q;
    tmo_d       = tmo_q;

    if (avs_read) begin
      rdata_d = (state_q == S_OUT) ? result_byte : status;
    end

    case (state_q)
      S_IDLE: begin
        if (avs_write) begin
          case (avs_writedata)
            8'h00: err_d = 1'b0;
            8'h01: begin
              state_d     = S_KEY;
              cnt_d       = '0;
              key_valid_d = 1'b0;
            end
            8'h02: begin
              if (key_valid_q) begin
                state_d = S_DATA;
                cnt_d   = '0;
              end else begin
                err_d = 1'b1;
              end
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      S_KEY: begin
        if (avs_write) begin
          key_d[byte_pos +: 8] = avs_writedata;
          cnt_d                = cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            key_valid_d = 1'b1;
            state_d     = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (avs_write) begin
          din_d[byte_pos +: 8] = avs_writedata;
          cnt_d                = cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            state_d = S_START;
          end
        end
      end
      S_START: begin
        tmo_d   = '0;
        state_d = S_BUSY;
      end
      S_BUSY: begin
        // Abort outranks a coincident completion; completion outranks timeout.
        if (avs_write && avs_writedata == 8'h00) begin
          state_d = S_IDLE;
        end else if (aes_done) begin
          result_d = aes_dout;
          state_d  = S_DONE;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_DONE: begin
        if (avs_write && avs_writedata == 8'h03) begin
          state_d = S_OUT;
          cnt_d   = '0;
        end else if (avs_write && avs_writedata == 8'h00) begin
          state_d = S_IDLE;
        end
      end
      S_OUT: begin
        if (avs_write) begin
          if (avs_writedata == 8'h00) begin
            state_d = S_IDLE;
          end
        end else if (avs_read) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (soft_reset) begin
      state_d     = S_IDLE;
      cnt_d       = '0;
      key_valid_d = 1'b0;
      err_d       = 1'b0;
      key_d       = '0;
      din_d       = '0;
      result_d    = '0;
      rdata_d     = '0;
      tmo_d       = '0;
    end
  end

  always_comb begin
    status      = {(state_q == S_START) || (state_q == S_BUSY),
                   state_q == S_DONE, key_valid_q, err_q, cnt_q};
    result_byte = result_q[byte_pos +: 8];
    aes_start   = (state_q == S_START);
  end

  assign avs_readdata = rdata_q;
  assign aes_key      = key_q;
  assign aes_din      = din_q;

endmodule

// File: tb/tb_aes_byte_ctrl.sv
// tb/tb_aes_byte_ctrl.sv - directed self-checking bench for aes_byte_ctrl
module tb_aes_byte_ctrl;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         soft_reset = 1'b0;
  logic         avs_read = 1'b0;
  logic         avs_write = 1'b0;
  logic [7:0]   wdata = 8'h00;
  logic [7:0]   rdata;
  logic [127:0] key;
  logic [127:0] din;
  logic         start;
  logic         done = 1'b0;
  logic [127:0] dout = '0;

  localparam logic [127:0] KEY_EXP = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] DIN_EXP = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] RES     = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  int n_assert = 0;
  int n_fail   = 0;
  int n_start  = 0;

  aes_byte_ctrl #(.TIMEOUT(16)) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .soft_reset    (soft_reset),
    .avs_read      (avs_read),
    .avs_write     (avs_write),
    .avs_writedata (wdata),
    .avs_readdata  (rdata),
    .aes_key       (key),
    .aes_din       (din),
    .aes_start     (start),
    .aes_done      (done),
    .aes_dout      (dout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (start) n_start++;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] b);
    avs_write = 1'b1;
    wdata     = b;
    @(posedge clk); #1;
    avs_write = 1'b0;
  endtask

  task automatic rd(output logic [7:0] d);
    avs_read = 1'b1;
    @(posedge clk); #1;
    avs_read = 1'b0;
    d = rdata;
  endtask

  task automatic chk_status(input string tag, input logic [7:0] exp);
    logic [7:0] d;
    rd(d);
    check(tag, {120'd0, d}, {120'd0, exp});
  endtask

  task automatic load_key();
    wr(8'h01);
    for (int i = 0; i < 16; i++) wr(8'(i));
  endtask

  task automatic load_data();
    wr(8'h02);
    for (int i = 0; i < 16; i++) wr(8'(i * 17));
  endtask

  // From state START: enter BUSY, then pulse done ten cycles after launch.
  task automatic run_done();
    @(posedge clk); #1;
    repeat (8) begin @(posedge clk); #1; end
    dout = RES;
    done = 1'b1;
    @(posedge clk); #1;
    done = 1'b0;
  endtask

  initial begin
    logic [7:0] d;

    repeat (2) @(posedge clk);
    #1;
    check("rst_rdata", {120'd0, rdata}, 128'd0);
    check("rst_key", key, 128'd0);
    check("rst_din", din, 128'd0);
    check("rst_start", {127'd0, start}, 128'd0);
    rst_n = 1'b1;
    chk_status("rst_status", 8'h00);

    wr(8'h02);
    chk_status("nokey_err", 8'h10);
    wr(8'h00);
    chk_status("err_clear", 8'h00);
    wr(8'h55);
    chk_status("bad_cmd_err", 8'h10);
    wr(8'h00);

    wr(8'h01);
    for (int i = 0; i < 8; i++) wr(8'(i));
    chk_status("key_cnt8", 8'h08);
    for (int i = 8; i < 16; i++) wr(8'(i));
    check("key_value", key, KEY_EXP);
    chk_status("key_valid", 8'h20);

    avs_read  = 1'b1;
    avs_write = 1'b1;
    wdata     = 8'h55;
    @(posedge clk); #1;
    avs_read  = 1'b0;
    avs_write = 1'b0;
    check("rw_pre_status", {120'd0, rdata}, {120'd0, 8'h20});
    chk_status("rw_post_status", 8'h30);
    wr(8'h00);

    load_data();
    check("start_pulse", {127'd0, start}, 128'd1);
    check("din_value", din, DIN_EXP);
    run_done();
    chk_status("done_status", 8'h60);
    check("one_start", n_start, 128'd1);
    wr(8'h03);
    for (int i = 0; i < 16; i++) begin
      rd(d);
      check($sformatf("out_byte%0d", i), {120'd0, d}, {120'd0, RES[127-8*i -: 8]});
    end
    chk_status("after_out", 8'h20);

    load_data();
    @(posedge clk); #1;
    repeat (14) begin @(posedge clk); #1; end
    chk_status("tmo_busy15", 8'ha0);
    chk_status("tmo_busy16", 8'ha0);
    chk_status("tmo_err", 8'h30);
    dout = ~RES;
    done = 1'b1;
    @(posedge clk); #1;
    done = 1'b0;
    chk_status("late_done", 8'h30);
    check("two_starts", n_start, 128'd2);
    wr(8'h00);

    load_data();
    repeat (4) begin @(posedge clk); #1; end
    avs_write = 1'b1;
    wdata     = 8'h00;
    done      = 1'b1;
    @(posedge clk); #1;
    avs_write = 1'b0;
    done      = 1'b0;
    chk_status("abort_status", 8'h20);
    wr(8'h03);
    chk_status("abort_no_out", 8'h30);
    wr(8'h00);
    check("three_starts", n_start, 128'd3);

    wr(8'h01);
    for (int i = 0; i < 7; i++) wr(8'(i));
    chk_status("key_cnt7", 8'h07);
    rst_n = 1'b0;
    #2;
    check("arst_key", key, 128'd0);
    check("arst_din", din, 128'd0);
    check("arst_rdata", {120'd0, rdata}, 128'd0);
    check("arst_start", {127'd0, start}, 128'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk_status("arst_status", 8'h00);

    load_key();
    load_data();
    run_done();
    wr(8'h03);
    rd(d);
    check("out2_byte0", {120'd0, d}, {120'd0, 8'h69});
    rd(d);
    rd(d);
    soft_reset = 1'b1;
    @(posedge clk); #1;
    soft_reset = 1'b0;
    check("srst_key", key, 128'd0);
    check("srst_din", din, 128'd0);
    check("srst_rdata", {120'd0, rdata}, 128'd0);
    check("srst_start", {127'd0, start}, 128'd0);
    chk_status("srst_status", 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
